pixel_write_queue: RTL and testbench
====================================

// Module: pixel_write_queue
// PURPOSE
//  Downstream of the chess/pointer painter: turns its multi-cycle print_enable pulses into single
//  valid/ready pixel writes toward the VGA framebuffer port. Buffers bursts in a small FIFO.
//  Optionally sweeps the whole screen to a background colour after reset.
// PARAMETERS
//  FIFO_DEPTH   8        entries; power of two, >= 2
//  SCR_W        160      screen width in pixels (clear sweep x range)
//  SCR_H        120      screen height in pixels (clear sweep y range)
//  CLEAR_COLOR  3'b000   colour written by the clear sweep
// PORTS
//  Clck          in   1                  clock, all logic on posedge
//  Reset         in   1                  reset, synchronous, active-low
//  paint_x_co    in   `SCR_WIDTH_BITS    painter x coordinate
//  paint_y_co    in   `SCR_HEIGHT_BITS   painter y coordinate
//  color         in   `COLOR_SIZE        painter colour
//  print_enable  in   1                  painter write strobe; high >= 1 cycle per pixel
//  fb_ready      in   1                  framebuffer accepts a write this cycle
//  fb_write      out  1                  write valid toward framebuffer
//  fb_x          out  `SCR_WIDTH_BITS    write x
//  fb_y          out  `SCR_HEIGHT_BITS   write y
//  fb_colour     out  `COLOR_SIZE        write colour
//  busy          out  1                  clear sweep running, or FIFO / output register not empty
//  overflow      out  1                  sticky: a capture was dropped
// BEHAVIOUR
//  - Reset (Reset==0 at posedge): fb_write=0, fb_x=0, fb_y=0, fb_colour=0, overflow=0,
//    FIFO emptied, pointers 0, print_enable history=0, busy=0 (=1 if CLEAR_ON_RESET_EN).
//    Reset mid-sweep or mid-handshake abandons everything; no write completes that cycle.
//  - Capture: one capture per rising edge of print_enable (now 1, previous sample 0).
//    {x,y,color} sampled on that same edge. A held-high strobe yields exactly one capture.
//  - Push: the capture enters the FIFO at the capture edge. If FIFO is full and no pop happens
//    that edge -> drop it, overflow<=1 until reset. Full with a pop on the same edge -> accept.
//  - Output register: a transfer happens at a posedge with fb_write&&fb_ready. fb_write and
//    fb_x/fb_y/fb_colour stay stable while fb_write=1 && fb_ready=0. The register reloads
//    from the FIFO head when empty or transferring, so back-to-back 1/clk throughput is possible.
//  - Latency: a capture at edge N into an empty FIFO and idle register gives fb_write=1 after edge N+1.
//  - Order: strict FIFO order. Pointers are log2(FIFO_DEPTH) bits plus one wrap bit.
//    Full = indices equal and wrap bits differ. Empty = both equal.
//  - FSM: S_CLEAR -> S_RUN. S_RUN is terminal until reset.
//    In S_CLEAR the output register is fed only by the sweep counter. Order: raster, x fastest,
//    (0,0)..(SCR_W-1,SCR_H-1), colour CLEAR_COLOR. The counter advances only on transfer.
//    Captures are still pushed into the FIFO during S_CLEAR.
//    After the transfer of (SCR_W-1,SCR_H-1): go to S_RUN and drain the FIFO.
//  - busy = (state==S_CLEAR) || !fifo_empty || fb_write.
// CONFIGURATION
//  CLEAR_ON_RESET_EN defined: reset enters S_CLEAR. A full sweep of SCR_W*SCR_H writes precedes
//    any queued pixel.
//  Undefined: reset enters S_RUN directly. No sweep counter is synthesised.
//    CLEAR_COLOR, SCR_W and SCR_H are unused.
// STRUCTURE
//  - header.v supplies `SCR_WIDTH_BITS, `SCR_HEIGHT_BITS and `COLOR_SIZE.
//  - Add `FB_CLEAR_COLOR and the state codes S_CLEAR/S_RUN to header.v.
//  - One sub-module, pixel_fifo: synchronous FIFO (push, pop, din, dout, full, empty).
//    Reset is synchronous, active-low.
//  - Top level holds the edge detector, sweep counter, FSM, output register and overflow flag.
// TESTING
//  1 print_enable high 3 cycles at (5,7,3'b110), fb_ready=1 -> exactly one fb_write:
//    (5,7,3'b110), asserted after the edge following capture.
//  2 fb_ready=0 for 10 cycles, 4 captures -> fb_write held with the first pixel, unchanged.
//    Then fb_ready=1 -> 4 writes in capture order on 4 consecutive cycles.
//  3 fb_ready=0, 9 captures with FIFO_DEPTH=8 -> register + 8 stored, 0 dropped.
//    A 10th capture -> overflow=1, remains 1 after the drain, cleared only by Reset=0.
//  4 CLEAR_ON_RESET_EN, SCR_W=4, SCR_H=2, fb_ready=1 -> 8 writes (0,0)..(3,1) colour 3'b000.
//    A capture at (2,2,3'b001) made mid-sweep follows as the 9th write.
//  5 Reset=0 asserted while fb_write=1 && fb_ready=0 -> next cycle fb_write=0, busy=0
//    (or sweep restarting at (0,0) with CLEAR_ON_RESET_EN), overflow=0.
//  6 Capture on the same edge as a pop with the FIFO full -> accepted, overflow stays 0.

Source files
------------

// File: rtl/pixel_write_queue_pkg.sv
// Shared widths, pixel record and FSM state codes for the pixel write queue.
// Replaces the screen-geometry macros of header.v with typed package constants.
package pixel_write_queue_pkg;

    localparam int SCR_WIDTH_BITS  = 8;
    localparam int SCR_HEIGHT_BITS = 7;
    localparam int COLOR_SIZE      = 3;

    localparam logic [COLOR_SIZE-1:0] FB_CLEAR_COLOR = 3'b000;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    typedef struct packed {
        logic [SCR_WIDTH_BITS-1:0]  x;
        logic [SCR_HEIGHT_BITS-1:0] y;
        logic [COLOR_SIZE-1:0]      colour;
    } pixel_t;

endpackage

// File: rtl/pixel_write_queue_fifo.sv
// pixel_fifo: synchronous FIFO with wrap-bit pointers; full when indices match
// and wrap bits differ, empty when the pointers are identical.
module pixel_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 18
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: storage is deliberately not reset; the pointers alone define which
    // entries are valid, and a resettable array would cost a reset net per bit.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/pixel_write_queue.sv
// Converts painter print_enable strobes into valid/ready framebuffer writes via a FIFO.
// Define CLEAR_ON_RESET_EN to sweep the screen with CLEAR_COLOR after every reset.
module pixel_write_queue
    import pixel_write_queue_pkg::*;
#(
    parameter int unsigned            FIFO_DEPTH  = 8,
    parameter int unsigned            SCR_W       = 160,
    parameter int unsigned            SCR_H       = 120,
    parameter logic [COLOR_SIZE-1:0]  CLEAR_COLOR = FB_CLEAR_COLOR
) (
    input  logic                       Clck,
    input  logic                       Reset,
    input  logic [SCR_WIDTH_BITS-1:0]  paint_x_co,
    input  logic [SCR_HEIGHT_BITS-1:0] paint_y_co,
    input  logic [COLOR_SIZE-1:0]      color,
    input  logic                       print_enable,
    input  logic                       fb_ready,
    output logic                       fb_write,
    output logic [SCR_WIDTH_BITS-1:0]  fb_x,
    output logic [SCR_HEIGHT_BITS-1:0] fb_y,
    output logic [COLOR_SIZE-1:0]      fb_colour,
    output logic                       busy,
    output logic                       overflow
);

    state_t state_q, state_d;
    pixel_t cap_pix, fifo_dout, out_q, out_d;
    logic   pe_q, capture, load;
    logic   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic   fb_write_q, fb_write_d, overflow_q, overflow_d;

    assign cap_pix    = '{x: paint_x_co, y: paint_y_co, colour: color};
    assign capture    = print_enable && !pe_q;
    assign load       = !fb_write_q || fb_ready;
    // A full FIFO still takes a capture when the head leaves on the same edge.
    assign fifo_push  = capture && (!fifo_full || fifo_pop);
    assign overflow_d = overflow_q || (capture && fifo_full && !fifo_pop);

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(pixel_t))
    ) u_fifo (
        .clk_i   (Clck),
        .rst_ni  (Reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (cap_pix),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef CLEAR_ON_RESET_EN
    localparam logic [SCR_WIDTH_BITS-1:0]  X_LAST = SCR_WIDTH_BITS'(SCR_W - 1);
    localparam logic [SCR_HEIGHT_BITS-1:0] Y_LAST = SCR_HEIGHT_BITS'(SCR_H - 1);

    logic [SCR_WIDTH_BITS-1:0]  sweep_x_q, sweep_x_d;
    logic [SCR_HEIGHT_BITS-1:0] sweep_y_q, sweep_y_d;
    logic                       sweep_last;

    assign sweep_last = (sweep_x_q == X_LAST) && (sweep_y_q == Y_LAST);
`else
    if (SCR_W == 0 || SCR_H == 0 || $bits(CLEAR_COLOR) != COLOR_SIZE) begin : g_bad_geometry
        $error("pixel_write_queue: invalid screen geometry");
    end
`endif

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        fb_write_d = fb_write_q;
        out_d      = out_q;
        fifo_pop   = 1'b0;
`ifdef CLEAR_ON_RESET_EN
        sweep_x_d  = sweep_x_q;
        sweep_y_d  = sweep_y_q;
`endif
        case (state_q)
`ifdef CLEAR_ON_RESET_EN
            S_CLEAR: begin
                if (!fb_write_q) begin
                    fb_write_d = 1'b1;
                    out_d      = '{x: sweep_x_q, y: sweep_y_q, colour: CLEAR_COLOR};
                end else if (fb_ready) begin
                    if (sweep_last) begin
                        // Hand over to the queue on the same edge to keep 1/clk throughput.
                        state_d    = S_RUN;
                        fifo_pop   = !fifo_empty;
                        fb_write_d = !fifo_empty;
                        if (!fifo_empty) out_d = fifo_dout;
                    end else begin
                        if (sweep_x_q == X_LAST) begin
                            sweep_x_d = '0;
                            sweep_y_d = sweep_y_q + 1'b1;
                        end else begin
                            sweep_x_d = sweep_x_q + 1'b1;
                        end
                        fb_write_d = 1'b1;
                        out_d      = '{x: sweep_x_d, y: sweep_y_d, colour: CLEAR_COLOR};
                    end
                end
            end
`endif
            S_RUN: begin
                if (load) begin
                    fifo_pop   = !fifo_empty;
                    fb_write_d = !fifo_empty;
                    if (!fifo_empty) out_d = fifo_dout;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge Clck) begin
        if (!Reset) begin
`ifdef CLEAR_ON_RESET_EN
            state_q    <= S_CLEAR;
            sweep_x_q  <= '0;
            sweep_y_q  <= '0;
`else
            state_q    <= S_RUN;
`endif
            pe_q       <= 1'b0;
            fb_write_q <= 1'b0;
            out_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
`ifdef CLEAR_ON_RESET_EN
            sweep_x_q  <= sweep_x_d;
            sweep_y_q  <= sweep_y_d;
`endif
            state_q    <= state_d;
            pe_q       <= print_enable;
            fb_write_q <= fb_write_d;
            out_q      <= out_d;
            overflow_q <= overflow_d;
        end
    end

    assign fb_write  = fb_write_q;
    assign fb_x      = out_q.x;
    assign fb_y      = out_q.y;
    assign fb_colour = out_q.colour;
    assign overflow  = overflow_q;
    assign busy      = (state_q == S_CLEAR) || !fifo_empty || fb_write_q;

endmodule

// File: tb/tb_pixel_write_queue.sv
// Directed self-checking bench for pixel_write_queue; builds with or without
// CLEAR_ON_RESET_EN (sweep geometry shrunk to 4x2).
module tb_pixel_write_queue;
    import pixel_write_queue_pkg::*;

    localparam int W = 4;
    localparam int H = 2;
`ifdef CLEAR_ON_RESET_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic                       Clck = 1'b0;
    logic                       Reset = 1'b0;
    logic [SCR_WIDTH_BITS-1:0]  paint_x_co = '0;
    logic [SCR_HEIGHT_BITS-1:0] paint_y_co = '0;
    logic [COLOR_SIZE-1:0]      color = '0;
    logic                       print_enable = 1'b0;
    logic                       fb_ready = 1'b0;
    logic                       fb_write;
    logic [SCR_WIDTH_BITS-1:0]  fb_x;
    logic [SCR_HEIGHT_BITS-1:0] fb_y;
    logic [COLOR_SIZE-1:0]      fb_colour;
    logic                       busy;
    logic                       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    pixel_write_queue #(
        .FIFO_DEPTH  (8),
        .SCR_W       (W),
        .SCR_H       (H),
        .CLEAR_COLOR (3'b000)
    ) dut (
        .Clck         (Clck),
        .Reset        (Reset),
        .paint_x_co   (paint_x_co),
        .paint_y_co   (paint_y_co),
        .color        (color),
        .print_enable (print_enable),
        .fb_ready     (fb_ready),
        .fb_write     (fb_write),
        .fb_x         (fb_x),
        .fb_y         (fb_y),
        .fb_colour    (fb_colour),
        .busy         (busy),
        .overflow     (overflow)
    );

    always #5 Clck = ~Clck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pix(input int x, input int y, input int c);
        return {14'b0, x[7:0], y[6:0], c[2:0]};
    endfunction

    function automatic logic [31:0] out_pix();
        return {14'b0, fb_x, fb_y, fb_colour};
    endfunction

    task automatic tick();
        @(negedge Clck);
    endtask

    task automatic pulse(input int x, input int y, input int c);
        paint_x_co   = x[7:0];
        paint_y_co   = y[6:0];
        color        = c[2:0];
        print_enable = 1'b1;
        tick();
        print_enable = 1'b0;
        tick();
    endtask

    task automatic sweep_check();
`ifdef CLEAR_ON_RESET_EN
        fb_ready = 1'b1;
        for (int i = 0; i < W * H; i++) begin
            tick();
            check("sweep_wr", fb_write, 1);
            check("sweep_px", out_pix(), pix(i % W, i / W, 0));
        end
        tick();
        check("sweep_end_wr", fb_write, 0);
        check("sweep_end_busy", busy, 0);
        fb_ready = 1'b0;
`endif
    endtask

    task automatic do_reset();
        Reset        = 1'b0;
        print_enable = 1'b0;
        fb_ready     = 1'b0;
        tick();
        tick();
        check("rst_wr", fb_write, 0);
        check("rst_px", out_pix(), 0);
        check("rst_ovf", overflow, 0);
        check("rst_busy", busy, CLR_EN);
        Reset = 1'b1;
        sweep_check();
    endtask

    initial begin
        logic [31:0] exp2 [4];

        do_reset();

        // 1: held strobe -> exactly one write, one cycle after the capture edge
        paint_x_co = 8'd5; paint_y_co = 7'd7; color = 3'b110;
        print_enable = 1'b1;
        fb_ready     = 1'b1;
        tick();
        check("t1_lat", fb_write, 0);
        tick();
        check("t1_wr", fb_write, 1);
        check("t1_px", out_pix(), pix(5, 7, 6));
        tick();
        check("t1_once", fb_write, 0);
        print_enable = 1'b0;
        tick();
        check("t1_idle", fb_write, 0);
        check("t1_busy", busy, 0);

        // 2: stalled output holds the first pixel, then 4 back-to-back writes
        fb_ready = 1'b0;
        exp2[0] = pix(1, 2, 1);
        exp2[1] = pix(3, 4, 2);
        exp2[2] = pix(10, 20, 3);
        exp2[3] = pix(159, 119, 7);
        pulse(1, 2, 1);
        check("t2_hold_a", out_pix(), exp2[0]);
        pulse(3, 4, 2);
        pulse(10, 20, 3);
        pulse(159, 119, 7);
        tick();
        tick();
        check("t2_hold_wr", fb_write, 1);
        check("t2_hold_b", out_pix(), exp2[0]);
        fb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t2_wr", fb_write, 1);
            check("t2_px", out_pix(), exp2[i]);
            tick();
        end
        check("t2_done", fb_write, 0);

        // 3: 9 captures fit (register + 8), the 10th is dropped and sticky
        do_reset();
        for (int i = 0; i < 9; i++) pulse(i * 3, i + 10, i);
        check("t3_ovf0", overflow, 0);
        check("t3_busy", busy, 1);
        pulse(100, 100, 7);
        check("t3_ovf1", overflow, 1);
        fb_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            check("t3_wr", fb_write, 1);
            check("t3_px", out_pix(), pix(i * 3, i + 10, i));
            tick();
        end
        check("t3_drained", fb_write, 0);
        check("t3_sticky", overflow, 1);

        // 5: reset during a stalled handshake abandons it and clears overflow
        fb_ready = 1'b0;
        pulse(9, 9, 1);
        check("t5_pre_wr", fb_write, 1);
        check("t5_pre_ovf", overflow, 1);
        Reset = 1'b0;
        tick();
        check("t5_wr", fb_write, 0);
        check("t5_busy", busy, CLR_EN);
        check("t5_ovf", overflow, 0);
        check("t5_px", out_pix(), 0);
        Reset = 1'b1;
        sweep_check();

        // 6: capture on the same edge as a pop with the FIFO full is accepted
        do_reset();
        for (int i = 0; i < 9; i++) pulse(i + 40, i + 50, i + 1);
        paint_x_co = 8'd77; paint_y_co = 7'd66; color = 3'b101;
        print_enable = 1'b1;
        fb_ready     = 1'b1;
        check("t6_head", out_pix(), pix(40, 50, 1));
        tick();
        print_enable = 1'b0;
        check("t6_ovf", overflow, 0);
        for (int i = 1; i < 9; i++) begin
            check("t6_px", out_pix(), pix(i + 40, i + 50, i + 1));
            tick();
        end
        check("t6_last_wr", fb_write, 1);
        check("t6_last_px", out_pix(), pix(77, 66, 5));
        tick();
        check("t6_done", fb_write, 0);
        check("t6_ovf_end", overflow, 0);

`ifdef CLEAR_ON_RESET_EN
        // 4: a capture made mid-sweep follows the full sweep as the 9th write
        Reset = 1'b0;
        fb_ready = 1'b0;
        tick();
        tick();
        Reset    = 1'b1;
        fb_ready = 1'b1;
        for (int i = 0; i < W * H; i++) begin
            if (i == 2) begin
                paint_x_co = 8'd2; paint_y_co = 7'd2; color = 3'b001;
                print_enable = 1'b1;
            end
            if (i == 3) print_enable = 1'b0;
            tick();
            check("t4_wr", fb_write, 1);
            check("t4_px", out_pix(), pix(i % W, i / W, 0));
        end
        tick();
        check("t4_9th_wr", fb_write, 1);
        check("t4_9th_px", out_pix(), pix(2, 2, 1));
        tick();
        check("t4_done", fb_write, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
